// File: rtl/macc_drain_if.sv
`default_nettype none
// ============================================================================
//  Module   : macc_drain_if
//  Purpose  : Row-streaming valid/ready bus from macc_drain to the writeback
//             path. One beat carries one FP16 row of the drained snapshot.
//  Signals  : valid  beat present (master -> slave)
//             ready  slave accepts beat (slave -> master)
//             row    AccCol FP16 words, element c in row[c]
//             idx    row index of the beat
//             last   beat is the final row of the drain
//  Revision : 1.0  initial release
// ============================================================================
interface macc_drain_if #(
  parameter int AccCol = 1,
  parameter int IdxW   = 1
);
  logic                   valid;
  logic                   ready;
  logic [AccCol-1:0][15:0] row;
  logic [IdxW-1:0]        idx;
  logic                   last;

  modport master (output valid, output row, output idx, output last, input ready);
  modport slave  (input valid, input row, input idx, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/macc_drain.sv
`default_nettype none
// ============================================================================
//  Module   : macc_drain
//  Purpose  : Read-side companion of the FP16 accumulator array. On a drain
//             request it snapshots the whole AccRow x AccCol accumulator and
//             clears the accumulator on the same edge, then streams the
//             snapshot one row per beat over a valid/ready bus.
//  Ports    : clk        clock, all state on posedge
//             rst_n      asynchronous active-low reset
//             start      drain request, only honoured while idle
//             accMM      live accumulator matrix, accMM[r][c] is FP16
//             acc_clear  clear to accumulator (combinational idle & start)
//             out        row stream (master side of macc_drain_if)
//             busy       high while streaming
//             done       one-cycle pulse after the last beat is accepted
//  Revision : 1.0  initial release
// ============================================================================
module macc_drain #(
  parameter int AccRow = 1,
  parameter int AccCol = 1
) (
  input  wire logic                               clk,
  input  wire logic                               rst_n,
  input  wire logic                               start,
  input  wire logic [AccRow-1:0][AccCol-1:0][15:0] accMM,
  output logic                                    acc_clear,
  macc_drain_if.master                            out,
  output logic                                    busy,
  output logic                                    done
);

  localparam int IdxW = (AccRow > 1) ? $clog2(AccRow) : 1;
  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(AccRow - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                               state, state_n;
  logic [IdxW-1:0]                      cnt, cnt_n;
  logic [AccRow-1:0][AccCol-1:0][15:0]  snap;
  logic                                 snap_load;
  logic                                 done_n;
  logic                                 is_last;
  logic [AccCol-1:0][15:0]              sel_row;

  assign is_last = (cnt == LAST_IDX);

  // Row select written as a compare-loop so the index width never has to
  // match the array depth exactly (AccRow need not be a power of two).
  always_comb begin
    sel_row = '0;
    for (int r = 0; r < AccRow; r++) begin
      if (cnt == IdxW'(r)) sel_row = snap[r];
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    snap_load = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = STREAM;
          cnt_n     = '0;
          snap_load = 1'b1;
        end
      end
      STREAM: begin
        if (out.ready) begin
          if (is_last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
      if (snap_load) snap <= accMM;
    end
  end

  // Clear is combinational so the accumulator drops its sum on exactly the
  // edge that captures it; gating with rst_n keeps it quiet during reset.
  assign acc_clear = rst_n && (state == IDLE) && start;

  assign busy      = (state == STREAM);
  assign out.valid = (state == STREAM);
  assign out.row   = (state == STREAM) ? sel_row : '0;
  assign out.idx   = (state == STREAM) ? cnt : '0;
  assign out.last  = (state == STREAM) && is_last;

endmodule
`default_nettype wire

// File: tb/tb_macc_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_macc_drain
//  Purpose  : Self-checking bench for macc_drain with AccRow=2, AccCol=2.
//             Per-cycle vector table plus hand-written reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_macc_drain;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic [1:0][1:0][15:0]     accMM;
  logic                      acc_clear;
  logic                      busy;
  logic                      done;

  macc_drain_if #(.AccCol(2), .IdxW(1)) bus ();

  macc_drain #(.AccRow(2), .AccCol(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .accMM     (accMM),
    .acc_clear (acc_clear),
    .out       (bus),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Matrix A = {{3C00,4000},{4200,4400}}, matrix B = {{BC00,C000},{C200,C400}}
  // with accMM[r][c]; a row packs element c at bits [16c+15:16c].
  logic [1:0][1:0][15:0] mat_a, mat_b;
  localparam logic [31:0] A0 = 32'h4000_3C00;
  localparam logic [31:0] A1 = 32'h4400_4200;
  localparam logic [31:0] B0 = 32'hC000_BC00;
  localparam logic [31:0] B1 = 32'hC400_C200;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        selb;
    logic        clr;
    logic        vld;
    logic        ix;
    logic        lst;
    logic [31:0] row;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic st, input logic rdy, input logic selb,
                              input logic clr, input logic vld, input logic ix,
                              input logic lst, input logic [31:0] row,
                              input logic bsy, input logic dn);
    vec_t v;
    v.st = st; v.rdy = rdy; v.selb = selb; v.clr = clr; v.vld = vld;
    v.ix = ix; v.lst = lst; v.row = row; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic clr, input logic vld,
                            input logic ix, input logic lst, input logic [31:0] row,
                            input logic bsy, input logic dn);
    chk({tag, " acc_clear"}, 32'(acc_clear), 32'(clr));
    chk({tag, " valid"},     32'(bus.valid), 32'(vld));
    chk({tag, " idx"},       32'(bus.idx),   32'(ix));
    chk({tag, " last"},      32'(bus.last),  32'(lst));
    chk({tag, " row"},       bus.row,        row);
    chk({tag, " busy"},      32'(busy),      32'(bsy));
    chk({tag, " done"},      32'(done),      32'(dn));
  endtask

  initial begin
    mat_a[0][0] = 16'h3C00; mat_a[0][1] = 16'h4000;
    mat_a[1][0] = 16'h4200; mat_a[1][1] = 16'h4400;
    mat_b[0][0] = 16'hBC00; mat_b[0][1] = 16'hC000;
    mat_b[1][0] = 16'hC200; mat_b[1][1] = 16'hC400;

    //            st rdy B  clr v ix l  row bsy dn
    // 1: basic drain, ready always high
    tv.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0,  0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 1, 1, A1, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    // 2: ready low for 3 cycles on beat 0
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 1, 1, A1, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    // 3: accumulator changes after the start edge
    tv.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0,  0, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 1, 1, A1, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  0, 1));
    // 4: start pulses during STREAM are ignored
    tv.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0,  0, 0));
    tv.push_back(mk(1, 0, 1, 0, 1, 0, 0, B0, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 0, 0, B0, 1, 0));
    tv.push_back(mk(1, 1, 0, 0, 1, 1, 1, B1, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0));
    // 5: start held across done starts a second drain in the done cycle
    tv.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0,  0, 0));
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 0, A0, 1, 0));
    tv.push_back(mk(1, 1, 1, 0, 1, 1, 1, A1, 1, 0));
    tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0,  0, 1));
    tv.push_back(mk(0, 1, 1, 0, 1, 0, 0, B0, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 1, 1, 1, B1, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  0, 1));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  0, 0));

    // Reset state, with start high to show acc_clear is held off
    rst_n = 1'b0; start = 1'b1; bus.ready = 1'b1; accMM = mat_a;
    #2;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_outs("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    rst_n = 1'b1;
    step();

    // Table-driven cycles: inputs applied, outputs checked before next edge
    for (int i = 0; i < tv.size(); i++) begin
      start     = tv[i].st;
      bus.ready = tv[i].rdy;
      accMM     = tv[i].selb ? mat_b : mat_a;
      #1;
      check_outs($sformatf("vec%0d", i), tv[i].clr, tv[i].vld, tv[i].ix,
                 tv[i].lst, tv[i].row, tv[i].bsy, tv[i].dn);
      step();
    end

    // 6: asynchronous reset after beat 0 accepted
    start = 1'b1; bus.ready = 1'b1; accMM = mat_a;
    step();
    start = 1'b0;
    #1;
    check_outs("rst6_beat0", 0, 1, 0, 0, A0, 1, 0);
    step();
    #1;
    check_outs("rst6_beat1", 0, 1, 1, 1, A1, 1, 0);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check_outs("rst6_async", 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    start = 1'b0;
    rst_n = 1'b1;
    #1;
    check_outs("rst6_nodone", 0, 0, 0, 0, 0, 0, 0);
    step();
    check_outs("rst6_nodone2", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1; accMM = mat_b;
    #1;
    check_outs("rst6_restart", 1, 0, 0, 0, 0, 0, 0);
    step();
    start = 1'b0;
    #1;
    check_outs("rst6_rbeat0", 0, 1, 0, 0, B0, 1, 0);
    step();
    #1;
    check_outs("rst6_rbeat1", 0, 1, 1, 1, B1, 1, 0);
    step();
    #1;
    check_outs("rst6_rdone", 0, 0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
